sti_serializer: RTL and testbench

- Parallel-to-serial transmit stage that sits directly upstream of the 8-bit serial-to-parallel collector.
- Accepts one 16-bit word per load strobe and frames it to 8/16/24/32 bits with selectable zero-fill placement and bit order.
- Shifts the frame out one bit per clock with a qualifying valid, the same bit/enable pair the downstream collector consumes.

---
 rtl/sti_serializer.sv | 102 ++++++++++
 tb/tb_sti_serializer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sti_serializer.sv
// sti_serializer: parallel-to-serial transmit stage.
// Frames a 16-bit word to 8/16/24/32 bits and shifts it out one bit per clock.
module sti_serializer #(
    parameter int DW = 16,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] pi_data,
    input  logic [1:0]    pi_length,
    input  logic          pi_low,
    input  logic          pi_fill,
    input  logic          pi_msb,
    input  logic          pi_end,
    output logic          so_data,
    output logic          so_valid,
    output logic          busy,
    output logic          stream_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state;
    logic [31:0]   frame;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last;
    logic          msb_q;
    logic          end_q;

    logic [31:0]   frame_next;
    logic [CW-1:0] last_next;
    logic [CW-1:0] idx;

    // W-1 = 8*(len+1)-1 is simply the length code followed by three ones
    assign last_next = {pi_length, 3'b111};

    // Place the word inside the 32-bit frame according to length and fill
    always_comb begin
        frame_next = 32'h0;
        case (pi_length)
            2'b00: frame_next = pi_low ? {24'h0, pi_data[15:8]}
                                       : {24'h0, pi_data[7:0]};
            2'b01: frame_next = {16'h0, pi_data};
            2'b10: frame_next = pi_fill ? {8'h00, pi_data, 8'h00}
                                        : {16'h0000, pi_data};
            default: frame_next = pi_fill ? {pi_data, 16'h0000}
                                          : {16'h0000, pi_data};
        endcase
    end

    // Sequencer: accept a word in IDLE, count bits in SHIFT, pulse DONE on stream end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            frame <= 32'h0;
            cnt   <= '0;
            last  <= '0;
            msb_q <= 1'b0;
            end_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        frame <= frame_next;
                        cnt   <= last_next;
                        last  <= last_next;
                        msb_q <= pi_msb;
                        end_q <= pi_end;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt == '0) begin
                        state <= end_q ? S_DONE : S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Counter runs W-1..0; LSB-first order mirrors it against W-1
    always_comb begin
        idx = msb_q ? cnt : (last - cnt);
    end

    assign so_valid    = (state == S_SHIFT);
    assign so_data     = so_valid & frame[idx];
    assign busy        = (state != S_IDLE);
    assign stream_done = (state == S_DONE);

endmodule

// File: tb/tb_sti_serializer.sv
// tb_sti_serializer: directed vector bench for sti_serializer.
// Frames are checked bit by bit plus a collected word and the framing strobes.
module tb_sti_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_low;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_end;
    logic        so_data;
    logic        so_valid;
    logic        busy;
    logic        stream_done;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  len;
        logic        low;
        logic        fill;
        logic        msb;
        logic        eos;
        logic [31:0] frame;
        int          w;
    } vec_t;

    vec_t tbl[8];

    sti_serializer #(.DW(16), .CW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .pi_data    (pi_data),
        .pi_length  (pi_length),
        .pi_low     (pi_low),
        .pi_fill    (pi_fill),
        .pi_msb     (pi_msb),
        .pi_end     (pi_end),
        .so_data    (so_data),
        .so_valid   (so_valid),
        .busy       (busy),
        .stream_done(stream_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        pi_data   = v.data;
        pi_length = v.len;
        pi_low    = v.low;
        pi_fill   = v.fill;
        pi_msb    = v.msb;
        pi_end    = v.eos;
        load      = 1'b1;
    endtask

    // Called at a negedge in an idle cycle; returns at a negedge in an idle cycle.
    task automatic send(input vec_t v, input bit spam);
        logic [31:0] coll_m;
        logic [31:0] coll_l;
        logic        eb;
        coll_m = 32'h0;
        coll_l = 32'h0;
        drive(v);
        @(negedge clk);
        load = 1'b0;
        for (int j = 0; j < v.w; j++) begin
            if (spam) begin
                load    = 1'b1;
                pi_data = 16'h5A5A ^ 16'(j);
                pi_msb  = ~v.msb;
                pi_end  = ~v.eos;
            end
            eb = v.msb ? v.frame[v.w - 1 - j] : v.frame[j];
            chk($sformatf("bit%0d", j), {so_valid, busy, so_data, stream_done},
                {1'b1, 1'b1, eb, 1'b0});
            coll_m = {coll_m[30:0], so_data};
            coll_l = {so_data, coll_l[31:1]};
            @(negedge clk);
        end
        load = 1'b0;
        chk("collect", v.msb ? coll_m : (coll_l >> (32 - v.w)), v.frame);
        chk("post", {so_valid, so_data, stream_done, busy},
            {1'b0, 1'b0, v.eos, v.eos});
        if (v.eos) begin
            @(negedge clk);
            chk("after_done", {so_valid, stream_done, busy}, 3'b000);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{16'hA53C, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h000000A5, 8};
        tbl[1] = '{16'hA53C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000003C, 8};
        tbl[2] = '{16'h8001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00008001, 16};
        tbl[3] = '{16'hFFFF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000FFFF, 32};
        tbl[4] = '{16'hFFFF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF0000, 32};
        tbl[5] = '{16'hFFFF, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00FFFF00, 24};
        tbl[6] = '{16'h1234, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00001234, 24};
        tbl[7] = '{16'h00C3, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00C30000, 32};

        rst = 1'b0;
        drive(tbl[0]);
        repeat (3) begin
            @(negedge clk);
            chk("reset", {so_valid, so_data, busy, stream_done}, 4'b0000);
        end
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send(tbl[i], 1'b0);
        end

        send(tbl[2], 1'b1);
        send(tbl[0], 1'b0);

        drive(tbl[6]);
        @(negedge clk);
        load = 1'b0;
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("abort_bit%0d", j), {so_valid, busy, so_data},
                {1'b1, 1'b1, tbl[6].frame[j]});
            if (j == 5) rst = 1'b0;
            @(negedge clk);
        end
        repeat (3) begin
            chk("abort", {so_valid, so_data, busy, stream_done}, 4'b0000);
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (30) begin
            chk("abort_quiet", {so_valid, busy, stream_done}, 3'b000);
            @(negedge clk);
        end
        send(tbl[3], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
